// File: rtl/led_scheduler.sv
// -----------------------------------------------------------------------------
// led_scheduler
//
// Time-shares an 8-LED bank between N_REQ status requesters. A granted
// requester's pattern is latched and shown for HOLD_CYCLES clocks, or until
// that requester drops its request. Grants rotate round-robin. With nothing
// requested, the bank shows a heartbeat blink.
//
// Build option:
//   LED_HEARTBEAT_EN  defined   -> idle blink, reset value of led is 8'hFF
//                     undefined -> no beat counter, idle led is 8'h00
// -----------------------------------------------------------------------------
module led_scheduler #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int BEAT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] pattern,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         led,
    output logic               busy
);

    // -------------------------------------------------------------------------
    // Derived sizes and constants
    // -------------------------------------------------------------------------
    localparam int PTR_W  = (N_REQ > 1)       ? $clog2(N_REQ)       : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_REQ - 1);

`ifdef LED_HEARTBEAT_EN
    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    // Value the bank shows on entry to IDLE (first heartbeat phase is "on").
    localparam logic [7:0]        IDLE_LED  = 8'hFF;
`else
    localparam logic [7:0]        IDLE_LED  = 8'h00;
`endif

    // Reject illegal configurations at elaboration time.
    if (N_REQ < 1 || N_REQ > 8) begin : g_bad_n_req
        $error("led_scheduler: N_REQ must be in 1..8");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("led_scheduler: HOLD_CYCLES must be >= 1");
    end
    if (BEAT_CYCLES < 1) begin : g_bad_beat
        $error("led_scheduler: BEAT_CYCLES must be >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t              state, next_state;
    logic [HOLD_W-1:0]   hold_cnt, hold_d;
    logic [PTR_W-1:0]    rr_ptr, rr_d;
    logic [PTR_W-1:0]    cur_idx, cur_d;     // requester currently shown
    logic [N_REQ-1:0]    grant_d;
    logic [7:0]          led_d;
    logic                busy_d;
`ifdef LED_HEARTBEAT_EN
    logic [BEAT_W-1:0]   beat_cnt, beat_d;
`endif

    // -------------------------------------------------------------------------
    // Arbitration helpers
    // -------------------------------------------------------------------------
    logic [7:0]          pat_arr [N_REQ];
    logic [PTR_W-1:0]    ptr_adv;            // rr_ptr value after the current slot
    logic [PTR_W-1:0]    arb_base;
    logic [PTR_W-1:0]    arb_idx;
    logic                arb_found;
    int                  arb_cand;
    logic                slot_end;
    logic                take;               // load a new winner this edge

    // Unpack the flat pattern bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pat_arr[i] = pattern[8*i +: 8];
        end
    end

    // Pointer value one past the current winner, wrapping at N_REQ.
    always_comb begin
        if (cur_idx == PTR_LAST) begin
            ptr_adv = '0;
        end else begin
            ptr_adv = cur_idx + PTR_W'(1);
        end
    end

    // A slot ends on hold expiry or when the shown requester lets go; both
    // together still count as one slot end.
    assign slot_end = (state == SHOW) && ((hold_cnt == HOLD_LAST) || !req[cur_idx]);

    // Rotating priority search. At a slot end the search already starts from
    // the advanced pointer so back-to-back grants follow round-robin order.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path can leave it unassigned and infer a latch.
        arb_base  = slot_end ? ptr_adv : rr_ptr;
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            arb_cand = int'(arb_base) + k;
            if (arb_cand >= N_REQ) begin
                arb_cand = arb_cand - N_REQ;
            end
            if (!arb_found && req[PTR_W'(arb_cand)]) begin
                arb_found = 1'b1;
                arb_idx   = PTR_W'(arb_cand);
            end
        end
    end

    assign take = arb_found && ((state == IDLE) || slot_end);

    // -------------------------------------------------------------------------
    // FSM: state register (also holds the registered outputs and counters)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            led      <= IDLE_LED;
            hold_cnt <= '0;
            rr_ptr   <= '0;
            cur_idx  <= '0;
`ifdef LED_HEARTBEAT_EN
            beat_cnt <= '0;
`endif
        end else begin
            state    <= next_state;
            grant    <= grant_d;
            busy     <= busy_d;
            led      <= led_d;
            hold_cnt <= hold_d;
            rr_ptr   <= rr_d;
            cur_idx  <= cur_d;
`ifdef LED_HEARTBEAT_EN
            beat_cnt <= beat_d;
`endif
        end
    end

    // FSM: next-state decision.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (arb_found) begin
                    next_state = SHOW;
                end
            end
            SHOW: begin
                if (slot_end && !arb_found) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM: next values of outputs, counters and pointer.
    always_comb begin
        grant_d = grant;
        led_d   = led;
        busy_d  = busy;
        hold_d  = hold_cnt;
        rr_d    = rr_ptr;
        cur_d   = cur_idx;
`ifdef LED_HEARTBEAT_EN
        beat_d  = beat_cnt;
`endif

        if (slot_end) begin
            rr_d = ptr_adv;
        end

        if (take) begin
            // New winner: latch its pattern now; later pattern changes are ignored.
            grant_d          = '0;
            grant_d[arb_idx] = 1'b1;
            led_d            = pat_arr[arb_idx];
            hold_d           = '0;
            busy_d           = 1'b1;
            cur_d            = arb_idx;
        end else if (slot_end) begin
            // Slot over and nobody waiting: back to the idle display.
            grant_d = '0;
            busy_d  = 1'b0;
            led_d   = IDLE_LED;
`ifdef LED_HEARTBEAT_EN
            beat_d  = '0;
`endif
        end else if (state == SHOW) begin
            hold_d = hold_cnt + HOLD_W'(1);
        end else begin
`ifdef LED_HEARTBEAT_EN
            // Heartbeat: flip the whole bank at the end of each phase.
            if (beat_cnt == BEAT_LAST) begin
                beat_d = '0;
                led_d  = ~led;
            end else begin
                beat_d = beat_cnt + BEAT_W'(1);
            end
`endif
        end
    end

endmodule
